// File: rtl/opc_pkg.sv
// Shared defaults, PC type and ring-index helper for the old-PC history buffer.
package opc_pkg;

    localparam int OPC_PC_WIDTH = 14;
    localparam int OPC_DEPTH    = 8;

    typedef logic [OPC_PC_WIDTH-1:0] pc_t;

    // Slot holding the entry idx steps back from the newest. Computed at 8 bits;
    // callers truncate to their pointer width, which is the mod-DEPTH wrap.
    function automatic logic [7:0] ring_idx(input logic [7:0] wptr, input logic [7:0] idx);
        return wptr - 8'd1 - idx;
    endfunction

endpackage

// File: rtl/opc_ring_mem.sv
// DEPTH x W register file: one synchronous write port, one synchronous
// read-first read port, no reset so it maps onto distributed RAM.
module opc_ring_mem #(
    parameter int W     = 14,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Read samples the old contents when it hits the slot being written.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/opc_history.sv
// Ring of the DEPTH most recently fetched PCs with freeze, clear, occupancy,
// wrap status and a one-cycle indexed read port for the debug interface.
module opc_history
    import opc_pkg::*;
#(
    parameter int PC_WIDTH = OPC_PC_WIDTH,
    parameter int DEPTH    = OPC_DEPTH,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       state_fetch,
    input  logic                       opcclk,
    input  logic                       opcinh,
    input  logic                       freeze,
    input  logic                       clr,
    input  logic [PC_WIDTH-1:0]        pc,
    input  logic                       rd_req,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [PC_WIDTH-1:0]        opc,
    output logic [PC_WIDTH-1:0]        rd_data,
    output logic                       rd_valid,
    output logic                       rd_miss,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       wrapped
);

    localparam int CW = $clog2(DEPTH+1);

    logic [IDX_W-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                wrapped_q, wrapped_d;
    logic [PC_WIDTH-1:0] opc_q, opc_d;
    logic                rd_valid_q, rd_miss_q, rd_zero_q;
    logic                cap, miss;
    logic [IDX_W-1:0]    raddr;
    logic [PC_WIDTH-1:0] mem_rdata;

    assign cap   = (state_fetch | opcclk) & ~opcinh & ~freeze & ~clr;
    assign miss  = CW'(rd_idx) >= count_q;
    assign raddr = IDX_W'(ring_idx(8'(wptr_q), 8'(rd_idx)));

    always_comb begin
        wptr_d    = wptr_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        opc_d     = opc_q;
        if (clr) begin
            wptr_d    = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
            opc_d     = '0;
        end else if (cap) begin
            wptr_d = wptr_q + IDX_W'(1);
            opc_d  = pc;
            if (count_q == CW'(DEPTH)) wrapped_d = 1'b1;
            else                       count_d   = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            opc_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_miss_q  <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            wrapped_q  <= wrapped_d;
            opc_q      <= opc_d;
            rd_valid_q <= rd_req;
            rd_miss_q  <= rd_req & miss;
            if (rd_req) rd_zero_q <= miss;
        end
    end

    // The RAM read register has no reset, so a miss (or nothing read since
    // reset) is masked to zero; both sides hold between requests.
    opc_ring_mem #(.W(PC_WIDTH), .DEPTH(DEPTH), .AW(IDX_W)) u_mem (
        .clk_i   (clk),
        .we_i    (cap),
        .waddr_i (wptr_q),
        .wdata_i (pc),
        .re_i    (rd_req),
        .raddr_i (raddr),
        .rdata_o (mem_rdata)
    );

    assign opc      = opc_q;
    assign rd_data  = rd_zero_q ? '0 : mem_rdata;
    assign rd_valid = rd_valid_q;
    assign rd_miss  = rd_miss_q;
    assign count    = count_q;
    assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_opc_history.sv
// Directed vector table plus randomized run against a queue-based history model.
module tb_opc_history;
    import opc_pkg::*;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       state_fetch, opcclk, opcinh, freeze, clr, rd_req;
    pc_t        pc, opc, rd_data;
    logic [2:0] rd_idx;
    logic       rd_valid, rd_miss, wrapped;
    logic [3:0] count;

    opc_history #(.PC_WIDTH(14), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .state_fetch(state_fetch), .opcclk(opcclk),
        .opcinh(opcinh), .freeze(freeze), .clr(clr), .pc(pc), .rd_req(rd_req),
        .rd_idx(rd_idx), .opc(opc), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_miss(rd_miss), .count(count), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sf, oc, inh, frz, cl, rq;
        int unsigned pcv, idx;
        int unsigned e_opc, e_cnt, e_rd;
        bit e_wr, e_rv, e_miss;
    } vec_t;

    vec_t tbl[$];
    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic row(input bit sf, oc, inh, frz, cl, input int unsigned pcv,
                       input bit rq, input int unsigned idx,
                       input int unsigned eo, ec, input bit ew,
                       input int unsigned erd, input bit erv, emiss);
        vec_t v;
        v.sf = sf; v.oc = oc; v.inh = inh; v.frz = frz; v.cl = cl; v.rq = rq;
        v.pcv = pcv; v.idx = idx; v.e_opc = eo; v.e_cnt = ec; v.e_wr = ew;
        v.e_rd = erd; v.e_rv = erv; v.e_miss = emiss;
        tbl.push_back(v);
    endtask

    task automatic drive(input bit sf, oc, inh, frz, cl, input int unsigned pcv,
                         input bit rq, input int unsigned idx);
        state_fetch = sf; opcclk = oc; opcinh = inh; freeze = frz; clr = cl;
        pc = pc_t'(pcv); rd_req = rq; rd_idx = 3'(idx);
    endtask

    task automatic chk_all(input int unsigned eo, ec, input bit ew,
                           input int unsigned erd, input bit erv, emiss);
        chk("opc", 32'(opc), eo);
        chk("count", 32'(count), ec);
        chk("wrapped", 32'(wrapped), 32'(ew));
        chk("rd_valid", 32'(rd_valid), 32'(erv));
        chk("rd_miss", 32'(rd_miss), 32'(emiss));
        chk("rd_data", 32'(rd_data), erd);
    endtask

    // Behavioural model: queue of captured PCs, newest at the back.
    int unsigned hist[$];
    int unsigned m_opc, m_rd;
    bit          m_wr, m_rv, m_miss;

    initial begin
        // sf oc inh frz clr  pc    rq idx   opc    cnt wr  rd     rv miss
        row(0,0,0,0,0, 0,      0,0,  0,     0, 0, 0,     0,0);
        row(1,0,0,0,0, 'h100,  0,0,  'h100, 1, 0, 0,     0,0);
        row(1,0,0,0,0, 'h101,  0,0,  'h101, 2, 0, 0,     0,0);
        row(1,0,0,0,0, 'h102,  0,0,  'h102, 3, 0, 0,     0,0);
        row(0,0,0,0,0, 0,      1,0,  'h102, 3, 0, 'h102, 1,0);
        row(0,0,0,0,0, 0,      1,1,  'h102, 3, 0, 'h101, 1,0);
        row(0,0,0,0,0, 0,      1,2,  'h102, 3, 0, 'h100, 1,0);
        row(0,0,0,0,0, 0,      1,3,  'h102, 3, 0, 0,     1,1);
        row(0,1,1,0,0, 'h3FFF, 0,0,  'h102, 3, 0, 0,     0,0);
        row(1,0,0,1,0, 'h3FFF, 0,0,  'h102, 3, 0, 0,     0,0);
        row(0,0,0,0,0, 0,      1,0,  'h102, 3, 0, 'h102, 1,0);
        row(1,0,0,0,0, 'h200,  1,0,  'h200, 4, 0, 'h102, 1,0);
        row(1,0,0,0,1, 'h300,  0,0,  0,     0, 0, 'h102, 0,0);
        row(0,0,0,0,0, 0,      1,0,  0,     0, 0, 0,     1,1);
        for (int k = 1; k <= 10; k++)
            row(1,0,0,0,0, k, 0,0, k, (k > 8) ? 8 : k, k > 8, 0, 0,0);
        row(0,0,0,0,0, 0,      1,7,  10,    8, 1, 3,     1,0);
        row(0,0,0,0,0, 0,      1,0,  10,    8, 1, 10,    1,0);
        row(1,0,0,0,0, 11,     1,7,  11,    8, 1, 3,     1,0);
        row(0,0,0,0,0, 0,      1,7,  11,    8, 1, 4,     1,0);
        row(0,1,0,0,0, 12,     0,0,  12,    8, 1, 4,     0,0);

        reset_n = 1'b0;
        drive(0,0,0,0,0, 0, 0,0);
        #1;
        chk_all(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].sf, tbl[i].oc, tbl[i].inh, tbl[i].frz, tbl[i].cl,
                  tbl[i].pcv, tbl[i].rq, tbl[i].idx);
            @(posedge clk); #1;
            chk_all(tbl[i].e_opc, tbl[i].e_cnt, tbl[i].e_wr, tbl[i].e_rd,
                    tbl[i].e_rv, tbl[i].e_miss);
        end

        // Reset landing while a read result is on the port.
        drive(0,0,0,0,0, 0, 1,0);
        @(posedge clk); #1;
        drive(0,0,0,0,0, 0, 0,0);
        chk("pend_rd_valid", 32'(rd_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_opc", 32'(opc), 0);
        @(negedge clk);
        reset_n = 1'b1;

        hist.delete();
        m_opc = 0; m_rd = 0; m_wr = 0; m_rv = 0; m_miss = 0;
        for (int n = 0; n < 600; n++) begin
            bit sf, oc, inh, frz, cl, rq, cap;
            int unsigned pcv, idx;
            sf  = ($urandom_range(0, 2) != 0);
            oc  = ($urandom_range(0, 5) == 0);
            inh = ($urandom_range(0, 5) == 0);
            frz = ($urandom_range(0, 7) == 0);
            cl  = ($urandom_range(0, 59) == 0);
            rq  = ($urandom_range(0, 1) == 1);
            pcv = $urandom_range(0, 16383);
            idx = $urandom_range(0, D - 1);

            m_rv = rq;
            m_miss = 0;
            if (rq) begin
                if (idx < hist.size()) m_rd = hist[hist.size() - 1 - idx];
                else begin m_rd = 0; m_miss = 1; end
            end
            cap = (sf | oc) & ~inh & ~frz & ~cl;
            if (cl) begin
                hist.delete(); m_wr = 0; m_opc = 0;
            end else if (cap) begin
                hist.push_back(pcv);
                m_opc = pcv;
                if (hist.size() > D) begin void'(hist.pop_front()); m_wr = 1; end
            end

            drive(sf, oc, inh, frz, cl, pcv, rq, idx);
            @(posedge clk); #1;
            chk_all(m_opc, hist.size(), m_wr, m_rd, m_rv, m_miss);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/opc_history.md
# opc_history

Parametrised old-PC save buffer for the CADR-class microsequencer. It extends the single-entry old-PC save register into a DEPTH-entry ring of recently fetched PCs, captured under the same fetch/opcclk/opcinh qualification. It adds a freeze control, a synchronous clear, occupancy and wrap status, and a registered indexed read port for the debug/console interface. It sits beside the PC register and feeds both the debug bus and the existing `opc` consumers, which keep their current view of the newest entry.

## Interface
Parameters:
- `PC_WIDTH`, 14: width of `pc` and of every stored entry.
- `DEPTH`, 8: number of history entries; power of two, 2..256.
- `IDX_W`, $clog2(DEPTH): width of `rd_idx`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `state_fetch`  in  1  fetch-state strobe; capture request.
- `opcclk`  in  1  debug-forced capture request.
- `opcinh`  in  1  capture inhibit.
- `freeze`  in  1  level; while high, no capture occurs and the history is held.
- `clr`  in  1  synchronous clear of history state.
- `pc`  in  PC_WIDTH  current PC.
- `rd_req`  in  1  single-cycle read request.
- `rd_idx`  in  IDX_W  entries back from newest; 0 selects the newest entry.
- `opc`  out  PC_WIDTH  newest captured PC.
- `rd_data`  out  PC_WIDTH  read result.
- `rd_valid`  out  1  one-cycle pulse that qualifies `rd_data`.
- `rd_miss`  out  1  with `rd_valid`: `rd_idx` was at or beyond `count`.
- `count`  out  $clog2(DEPTH+1)  valid entries, 0..DEPTH.
- `wrapped`  out  1  sticky; set when a capture overwrites an entry.

## Operation
- Capture condition: `cap = (state_fetch | opcclk) & ~opcinh & ~freeze & ~clr`.
- On a `cap` cycle, the block performs all of these:
  - `mem[wptr] <= pc`.
  - `wptr <= wptr+1`, wrapping modulo DEPTH.
  - `opc <= pc`.
  - `count` increments, saturating at DEPTH.
  - If `count == DEPTH` before the capture, `wrapped <= 1`.
- Clear: `clr` zeroes `wptr`, `count`, `wrapped` and `opc`. It does not touch `rd_valid` or an in-flight read. `clr` beats capture in the same cycle. RAM contents are not cleared; `count` makes them unreachable.
- Read:
  - `rd_req` samples `rd_idx` and the pre-update state of the same cycle.
  - Selected entry is `mem[(wptr-1-rd_idx) mod DEPTH]`.
  - If `rd_idx >= count`: `rd_data = 0` and `rd_miss = 1`.
  - Reads never disturb capture. Back-to-back `rd_req` is allowed, one result per cycle.
- `freeze` has no effect on reads or `clr`.
- Reset values: `opc=0`, `rd_data=0`, `rd_valid=0`, `rd_miss=0`, `count=0`, `wrapped=0`, `wptr=0`. RAM contents are undefined.
- Reset asserted mid-operation aborts any pending read; `rd_valid` is forced low immediately (asynchronously).

## Timing
- Capture latency is 1: `pc` present in cycle N appears on `opc` and in `count` after edge N.
- Read latency is 1: `rd_req` in cycle N gives `rd_valid`, `rd_data` and `rd_miss` in cycle N+1, for exactly one cycle.
- Read and capture in the same cycle: the read returns pre-capture data. Example: `rd_idx=0` returns the old `opc`, not the incoming `pc`.
- `rd_data` holds its last value when `rd_valid` is low.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `opc_pkg`:
  - Default `PC_WIDTH` and `DEPTH`.
  - The `pc_t` typedef.
  - A function computing ring index from `wptr` and `rd_idx`.
- Sub-module `opc_ring_mem`:
  - DEPTH x PC_WIDTH register file.
  - One synchronous write port and one synchronous read port, no reset.
  - Infers distributed RAM.
- The top level holds the pointers, counters, flags and read pipeline.

## Test plan
- Reset, then three captures with `state_fetch=1` and `pc` = 0x0100, 0x0101, 0x0102. Required: `opc=0x0102`, `count=3`. `rd_idx` 0/1/2 returns 0x0102/0x0101/0x0100; `rd_idx=3` gives `rd_miss=1`, `rd_data=0`.
- `opcclk=1` with `opcinh=1`, or `freeze=1`, while `pc=0x3FFF`. Required: no change to `opc`, `count` or history.
- DEPTH=8, ten captures with `pc` = 1..10. Required: `count=8`, `wrapped=1`, `rd_idx=7` returns 3, `rd_idx=0` returns 10.
- Same-cycle capture of `pc=0x0200` and `rd_req` with `rd_idx=0`, `opc=0x0102`. Required: `rd_data=0x0102` next cycle, and `opc=0x0200`.
- `clr` asserted together with a capture, then a read at `rd_idx=0`. Required: `count=0`, `wrapped=0`, `opc=0`, read gives `rd_miss=1`. Separately, `reset_n` low during a pending read drops `rd_valid` immediately.
